// File: rtl/chnl_pkg.sv
// Shared constants for the CHNL record framer and the host-side record decoder.
// Trailer word layout: magic[31:24], seq[23:16], payload beat count[15:0].
package chnl_pkg;

   localparam logic [7:0] MAGIC_OK    = 8'hA5;
   localparam logic [7:0] MAGIC_TRUNC = 8'h5A;

   localparam int unsigned MAGIC_LSB = 24;
   localparam int unsigned SEQ_LSB   = 16;
   localparam int unsigned CNT_LSB   = 0;

   typedef logic [1:0] state_t;

   localparam state_t S_DATA    = 2'd0;
   localparam state_t S_TRAILER = 2'd1;
   localparam state_t S_PAD     = 2'd2;

   function automatic logic [31:0] trailer_word(input logic trunc, input logic [7:0] seq,
                                                input logic [15:0] cnt);
      logic [7:0] magic;
      magic = trunc ? MAGIC_TRUNC : MAGIC_OK;
      return (32'(magic) << MAGIC_LSB) | (32'(seq) << SEQ_LSB) | (32'(cnt) << CNT_LSB);
   endfunction

endpackage

// File: rtl/chnl_tx_framer.sv
// Record framer ahead of the CHNL transmitter: passes payload through, then appends a
// trailer beat and zero padding so every record fills whole CHNL_ALIGN-word blocks.
module chnl_tx_framer
   import chnl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CHNL_ALIGN = 4,
   parameter int unsigned MAX_BEATS  = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_val,
   output logic                  i_rdy,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_last,
   output logic                  o_val,
   input  logic                  o_rdy,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [31:0]           o_rec_cnt
);

   localparam int unsigned REC_BEATS = CHNL_ALIGN * 32 / DATA_WIDTH;
   localparam int unsigned PW        = $clog2(REC_BEATS) + 1;

   state_t        state_q, state_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [7:0]    seq_q, seq_d;
   logic          trunc_q, trunc_d;
   logic [31:0]   rec_cnt_q, rec_cnt_d;

   logic          xfer;
   logic          pos_wrap;
   logic [PW-1:0] pos_inc;
   logic [15:0]   cnt_inc;
   logic          at_max;

   assign xfer     = o_val && o_rdy;
   assign pos_wrap = (pos_q == PW'(REC_BEATS - 1));
   assign pos_inc  = pos_wrap ? '0 : pos_q + 1'b1;
   assign cnt_inc  = cnt_q + 16'd1;
   assign at_max   = (cnt_inc == 16'(MAX_BEATS));

   assign o_rec_cnt = rec_cnt_q;

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      cnt_d     = cnt_q;
      seq_d     = seq_q;
      trunc_d   = trunc_q;
      rec_cnt_d = rec_cnt_q;
      o_val     = 1'b0;
      i_rdy     = 1'b0;
      o_data    = '0;

      case (state_q)
         S_DATA: begin
            o_val  = i_val;
            i_rdy  = o_rdy;
            o_data = i_data;
            if (xfer) begin
               cnt_d = cnt_inc;
               pos_d = pos_inc;
               // Hitting the beat limit without i_last splits the record here.
               if (i_last || at_max) begin
                  state_d = S_TRAILER;
                  trunc_d = !i_last;
               end
            end
         end
         S_TRAILER: begin
            o_val        = 1'b1;
            o_data[31:0] = trailer_word(trunc_q, seq_q, cnt_q);
            if (xfer) begin
               seq_d     = seq_q + 8'd1;
               rec_cnt_d = rec_cnt_q + 32'd1;
               cnt_d     = '0;
               trunc_d   = 1'b0;
               pos_d     = pos_inc;
               state_d   = pos_wrap ? S_DATA : S_PAD;
            end
         end
         S_PAD: begin
            o_val = 1'b1;
            if (xfer) begin
               pos_d = pos_inc;
               if (pos_wrap) state_d = S_DATA;
            end
         end
         default: state_d = S_DATA;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_DATA;
         pos_q     <= '0;
         cnt_q     <= '0;
         seq_q     <= '0;
         trunc_q   <= 1'b0;
         rec_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         cnt_q     <= cnt_d;
         seq_q     <= seq_d;
         trunc_q   <= trunc_d;
         rec_cnt_q <= rec_cnt_d;
      end
   end

endmodule
